// File: rtl/ysyx_210544_dcache_core.sv
// ysyx_210544_dcache_core: direct-mapped, write-back, write-allocate data cache.
// 64-byte lines, 2**INDEX_W lines. Line transfers to the cache AXI unit are
// single 512-bit request/ack transactions (writeback op=1, refill op=0).
// Optional macro DCACHE_PERF_CNT_EN adds first-lookup hit/miss counters.
module ysyx_210544_dcache_core #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_dcache_req,
  input  logic [63:0]  i_dcache_addr,
  input  logic         i_dcache_op,
  input  logic [63:0]  i_dcache_wdata,
  input  logic [7:0]   i_dcache_wstrb,
  output logic [63:0]  o_dcache_rdata,
  output logic         o_dcache_ack,
  output logic         o_cache_axi_req,
  output logic [63:0]  o_cache_axi_addr,
  output logic         o_cache_axi_op,
  output logic [511:0] o_cache_axi_wdata,
  input  logic [511:0] i_cache_axi_rdata,
  input  logic         i_cache_axi_ack
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  o_perf_hit,
  output logic [31:0]  o_perf_miss
`endif
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 26 - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB_REQ,
    S_WB_GAP,
    S_FILL_REQ
  } state_e;

  state_e             state_q;
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [511:0]       data_q [LINES];

  // Latched LSU request
  logic [25:0]        line_addr_q;
  logic [2:0]         word_q;
  logic               op_q;
  logic [63:0]        wdata_q;
  logic [7:0]         wstrb_q;
  logic               first_q;

  // Registered outputs
  logic [63:0]        rdata_q;
  logic               ack_q;
  logic               axi_req_q;
  logic [63:0]        axi_addr_q;
  logic               axi_op_q;
  logic [511:0]       axi_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]        perf_hit_q;
  logic [31:0]        perf_miss_q;
`endif

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [511:0]       cur_line;
  logic [63:0]        cur_word;
  logic [511:0]       merged_line;
  logic               hit;
  logic               fill_we;
  logic               hit_we;
  logic               unused_addr;

  assign unused_addr = ^{i_dcache_addr[63:32], i_dcache_addr[2:0]};

  assign idx      = line_addr_q[INDEX_W-1:0];
  assign req_tag  = line_addr_q[25:INDEX_W];
  assign cur_line = data_q[idx];
  assign cur_word = cur_line[word_q*64 +: 64];
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign fill_we  = (state_q == S_FILL_REQ) && i_cache_axi_ack;
  assign hit_we   = (state_q == S_LOOKUP) && hit && op_q;

  // Byte-merge the latched write data into the selected word of the line
  always_comb begin
    merged_line = cur_line;
    for (int unsigned b = 0; b < 8; b++) begin
      if (wstrb_q[b]) begin
        merged_line[word_q*64 + b*8 +: 8] = wdata_q[b*8 +: 8];
      end
    end
  end

  // Tag and data storage (not reset); refill has priority over store-hit merge
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we) begin
        data_q[idx] <= i_cache_axi_rdata;
        tag_q[idx]  <= req_tag;
      end else if (hit_we) begin
        data_q[idx] <= merged_line;
      end
    end
  end

  // Control FSM with registered LSU/AXI outputs and valid/dirty bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      line_addr_q <= '0;
      word_q      <= '0;
      op_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      first_q     <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      axi_req_q   <= 1'b0;
      axi_addr_q  <= '0;
      axi_op_q    <= 1'b0;
      axi_wdata_q <= '0;
`ifdef DCACHE_PERF_CNT_EN
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_dcache_req && !ack_q) begin
            line_addr_q <= i_dcache_addr[31:6];
            word_q      <= i_dcache_addr[5:3];
            op_q        <= i_dcache_op;
            wdata_q     <= i_dcache_wdata;
            wstrb_q     <= i_dcache_wstrb;
            first_q     <= 1'b1;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          first_q <= 1'b0;
`ifdef DCACHE_PERF_CNT_EN
          if (first_q) begin
            if (hit) perf_hit_q  <= perf_hit_q + 32'd1;
            else     perf_miss_q <= perf_miss_q + 32'd1;
          end
`endif
          if (hit) begin
            ack_q <= 1'b1;
            if (op_q) dirty_q[idx] <= 1'b1;
            else      rdata_q      <= cur_word;
            state_q <= S_IDLE;
          end else if (valid_q[idx] && dirty_q[idx]) begin
            axi_req_q   <= 1'b1;
            axi_op_q    <= 1'b1;
            axi_addr_q  <= {32'd0, tag_q[idx], idx, 6'd0};
            axi_wdata_q <= cur_line;
            state_q     <= S_WB_REQ;
          end else begin
            axi_req_q  <= 1'b1;
            axi_op_q   <= 1'b0;
            axi_addr_q <= {32'd0, line_addr_q, 6'd0};
            state_q    <= S_FILL_REQ;
          end
        end
        S_WB_REQ: begin
          if (i_cache_axi_ack) begin
            axi_req_q <= 1'b0;
            state_q   <= S_WB_GAP;
          end
        end
        // One low cycle on req so the AXI unit sees a fresh rising edge
        S_WB_GAP: begin
          axi_req_q  <= 1'b1;
          axi_op_q   <= 1'b0;
          axi_addr_q <= {32'd0, line_addr_q, 6'd0};
          state_q    <= S_FILL_REQ;
        end
        S_FILL_REQ: begin
          if (i_cache_axi_ack) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            axi_req_q    <= 1'b0;
            state_q      <= S_LOOKUP;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_dcache_rdata    = rdata_q;
  assign o_dcache_ack      = ack_q;
  assign o_cache_axi_req   = axi_req_q;
  assign o_cache_axi_addr  = axi_addr_q;
  assign o_cache_axi_op    = axi_op_q;
  assign o_cache_axi_wdata = axi_wdata_q;
`ifdef DCACHE_PERF_CNT_EN
  assign o_perf_hit        = perf_hit_q;
  assign o_perf_miss       = perf_miss_q;
`endif

endmodule
